// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants for the fetch-PC controller: reset vector, state codes, instruction size.
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
  localparam logic [31:0] INST_BYTES   = 32'd4;

  localparam logic [0:0] SEQ     = 1'b0;
  localparam logic [0:0] WAIT_DS = 1'b1;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC and request controller: sequential fetch, delay-slot-aware branch redirect,
// and exception/ERET redirect with priority over branches.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        br_valid,
  input  logic        brcal_out,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  input  logic        ex_flush,
  input  logic [31:0] ex_target,
  input  logic        fetch_stall,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  output logic        wrong_path_kill
);

  logic [31:0] pc_reg, tgt_reg, last_acc_pc, ds_pc;
  logic [0:0]  state;
  logic        started, accept, taken;

  // started keeps inst_req low for the first cycle after reset release
  assign inst_req  = started & ~fetch_stall;
  assign inst_addr = pc_reg;
  assign accept    = inst_req & inst_addr_ok;
  assign ds_pc     = br_pc + INST_BYTES;
  assign taken     = br_valid & brcal_out;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg          <= RESET_PC;
      tgt_reg         <= '0;
      last_acc_pc     <= RESET_PC - INST_BYTES;
      state           <= SEQ;
      started         <= 1'b0;
      wrong_path_kill <= 1'b0;
    end else begin
      started         <= 1'b1;
      wrong_path_kill <= 1'b0;
      if (accept) last_acc_pc <= pc_reg;

      if (ex_flush) begin
        pc_reg <= ex_target;
        state  <= SEQ;
      end else if (state == WAIT_DS) begin
        // branches seen here sit in a delay slot and are ignored
        if (accept) begin
          pc_reg <= tgt_reg;
          state  <= SEQ;
        end
      end else if (taken && pc_reg == ds_pc) begin
        if (accept) begin
          pc_reg <= br_target;
        end else begin
          tgt_reg <= br_target;
          state   <= WAIT_DS;
        end
      end else if (taken) begin
        // delay slot already out; anything fetched beyond it is wrong-path
        pc_reg          <= br_target;
        wrong_path_kill <= (last_acc_pc != ds_pc) | accept;
      end else if (accept) begin
        pc_reg <= pc_reg + INST_BYTES;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural fetch-stream model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        br_valid = 1'b0, brcal_out = 1'b0, ex_flush = 1'b0;
  logic        fetch_stall = 1'b0, inst_addr_ok = 1'b0;
  logic [31:0] br_pc = '0, br_target = '0, ex_target = '0;
  logic        inst_req, wrong_path_kill;
  logic [31:0] inst_addr;

  int n_pass = 0;
  int n_total = 0;

  // model: current fetch address, whether fetching has started, a pending
  // post-delay-slot redirect, last accepted address, and kill due next cycle
  logic [31:0] m_pc, m_pend_tgt, m_last;
  logic        m_started, m_pend, m_kill;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .resetn(resetn), .br_valid(br_valid), .brcal_out(brcal_out),
    .br_pc(br_pc), .br_target(br_target), .ex_flush(ex_flush), .ex_target(ex_target),
    .fetch_stall(fetch_stall), .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .wrong_path_kill(wrong_path_kill)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = RPC; m_last = RPC - 32'd4; m_started = 1'b0;
    m_pend = 1'b0; m_pend_tgt = '0; m_kill = 1'b0;
  endtask

  // one clock: drive inputs, compare at negedge, advance model across posedge
  task automatic step(input logic bv, input logic bc, input logic [31:0] bpc,
                      input logic [31:0] btg, input logic fl, input logic [31:0] etg,
                      input logic st, input logic ok);
    logic        acc, req, kill_n;
    logic [31:0] ds, pc_n;
    br_valid = bv; brcal_out = bc; br_pc = bpc; br_target = btg;
    ex_flush = fl; ex_target = etg; fetch_stall = st; inst_addr_ok = ok;
    @(negedge clk);
    if (!resetn) model_reset();
    req = m_started && !st;
    chk("inst_req", {31'b0, inst_req}, {31'b0, req});
    chk("inst_addr", inst_addr, m_pc);
    chk("kill", {31'b0, wrong_path_kill}, {31'b0, m_kill});
    if (resetn) begin
      acc = req && ok;
      ds = bpc + 32'd4;
      pc_n = m_pc;
      kill_n = 1'b0;
      if (fl) begin
        pc_n = etg; m_pend = 1'b0;
      end else if (m_pend) begin
        if (acc) begin pc_n = m_pend_tgt; m_pend = 1'b0; end
      end else if (bv && bc) begin
        if (m_pc != ds) begin
          pc_n = btg;
          kill_n = (m_last != ds) || acc;
        end else if (acc) pc_n = btg;
        else begin m_pend = 1'b1; m_pend_tgt = btg; end
      end else if (acc) pc_n = m_pc + 32'd4;
      if (acc) m_last = m_pc;
      m_pc = pc_n; m_kill = kill_n; m_started = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ok);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, ok);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle(1'b1);
    idle(1'b1);
    chk("rst_addr", inst_addr, 32'hBFC0_0000);
    chk("rst_req", {31'b0, inst_req}, 32'd0);
    resetn = 1'b1;
    idle(1'b1);  // first cycle after release: no request, nothing accepted
  endtask

  initial begin
    model_reset();
    #2;
    do_reset();
    // sequential fetch: BFC00000, BFC00004, BFC00008 accepted in turn
    chk("seq_req", {31'b0, inst_req}, 32'd1);
    chk("seq0", inst_addr, 32'hBFC0_0000);
    idle(1'b1); chk("seq1", inst_addr, 32'hBFC0_0004);
    idle(1'b1); chk("seq2", inst_addr, 32'hBFC0_0008);
    idle(1'b1); chk("seq3", inst_addr, 32'hBFC0_000C);

    // taken branch, delay slot already accepted, nothing beyond it accepted
    do_reset();
    idle(1'b1); idle(1'b1);
    step(1'b1, 1'b1, 32'hBFC0_0000, 32'hBFC0_0100, 1'b0, '0, 1'b0, 1'b0);
    chk("br_tgt", inst_addr, 32'hBFC0_0100);
    chk("br_nokill", {31'b0, wrong_path_kill}, 32'd0);

    // same, but BFC00008 accepted alongside br_valid -> one kill pulse
    do_reset();
    idle(1'b1); idle(1'b1);
    step(1'b1, 1'b1, 32'hBFC0_0000, 32'hBFC0_0100, 1'b0, '0, 1'b0, 1'b1);
    chk("brk_tgt", inst_addr, 32'hBFC0_0100);
    chk("brk_kill", {31'b0, wrong_path_kill}, 32'd1);
    idle(1'b0);
    chk("brk_kill_end", {31'b0, wrong_path_kill}, 32'd0);

    // delay slot pending under stall
    do_reset();
    idle(1'b1);
    step(1'b1, 1'b1, 32'hBFC0_0000, 32'hBFC0_0200, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1);
      chk("ds_hold", inst_addr, 32'hBFC0_0004);
    end
    idle(1'b1);
    chk("ds_redirect", inst_addr, 32'hBFC0_0200);

    // not-taken branch
    step(1'b1, 1'b0, 32'hBFC0_01FC, 32'hBFC0_0900, 1'b0, '0, 1'b0, 1'b1);
    chk("nt_addr", inst_addr, 32'hBFC0_0204);
    chk("nt_kill", {31'b0, wrong_path_kill}, 32'd0);

    // flush beats a same-cycle taken branch
    step(1'b1, 1'b1, 32'hBFC0_0200, 32'hBFC0_0A00, 1'b1, 32'hBFC0_0380, 1'b0, 1'b1);
    chk("fl_addr", inst_addr, 32'hBFC0_0380);
    idle(1'b1);
    chk("fl_seq", inst_addr, 32'hBFC0_0384);

    // flush abandons WAIT_DS
    step(1'b1, 1'b1, 32'hBFC0_0380, 32'hBFC0_0500, 1'b0, '0, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'hBFC0_0600, 1'b1, 1'b1);
    chk("flw_addr", inst_addr, 32'hBFC0_0600);
    idle(1'b1);
    chk("flw_seq", inst_addr, 32'hBFC0_0604);

    // wrap past top of address space
    step(1'b0, 1'b0, '0, '0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    chk("wrap_pre", inst_addr, 32'hFFFF_FFFC);
    idle(1'b1);
    chk("wrap", inst_addr, 32'h0000_0000);

    // reset in WAIT_DS discards the pending target
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 32'hBFC0_0700, 1'b0, '0, 1'b1, 1'b1);
    do_reset();
    chk("mrst_addr", inst_addr, 32'hBFC0_0000);
    idle(1'b1);
    chk("mrst_seq", inst_addr, 32'hBFC0_0004);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        bv, bc, fl, st, ok;
      logic [31:0] bpc, btg;
      bv  = ($urandom_range(0, 4) == 0);
      bc  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       bpc = m_pc - 32'd4;    // delay slot still to fetch
        1:       bpc = m_last - 32'd4;  // delay slot just accepted
        default: bpc = m_last - 32'd8;  // delay slot accepted earlier
      endcase
      btg = $urandom;
      if ($urandom_range(0, 7) != 0) btg[1:0] = 2'b00;
      fl  = ($urandom_range(0, 40) == 0);
      st  = ($urandom_range(0, 5) == 0);
      ok  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 250) == 0) begin
        resetn = 1'b0; idle(1'b1); resetn = 1'b1;
      end
      step(bv, bc, bpc, btg, fl, $urandom & 32'hFFFF_FFFC, st, ok);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
